// File: rtl/ds_hazard_scoreboard_pkg.sv
// Shared defaults and bus-slice helper for the decode-stage hazard scoreboard.
package ds_hazard_scoreboard_pkg;
    localparam int XLEN_DEF    = 32;
    localparam int AW_DEF      = 5;
    localparam int NUM_RD_DEF  = 2;
    localparam int NUM_FWD_DEF = 3;
    localparam int CNT_W_DEF   = 2;
    localparam int REG_ZERO    = 0;
endpackage

`define DS_SLICE(idx, w) ((idx)*(w)) +: (w)

// File: rtl/ds_hazard_scoreboard_fwd_mux.sv
// One read port: priority search over bypass sources, falling back to the
// register file, with a stall when the operand is not yet available.
module ds_fwd_mux
    import ds_hazard_scoreboard_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int AW      = AW_DEF,
    parameter int NUM_FWD = NUM_FWD_DEF
) (
    input  logic [AW-1:0]           raddr,
    input  logic                    rneed,
    input  logic [XLEN-1:0]         rf_rdata,
    input  logic                    pending,
    input  logic [NUM_FWD-1:0]      fwd_we,
    input  logic [NUM_FWD-1:0]      fwd_ready,
    input  logic [NUM_FWD*AW-1:0]   fwd_waddr,
    input  logic [NUM_FWD*XLEN-1:0] fwd_wdata,
    output logic [XLEN-1:0]         value,
    output logic                    stall
);

    logic hit;

    always_comb begin
        value = rf_rdata;
        stall = 1'b0;
        hit   = 1'b0;
        if (raddr == AW'(REG_ZERO)) begin
            value = '0;
        end else begin
            // Lowest index is the youngest producer and must win.
            for (int j = 0; j < NUM_FWD; j++) begin
                if (!hit && fwd_we[j] && (fwd_waddr[`DS_SLICE(j, AW)] == raddr)) begin
                    hit = 1'b1;
                    if (fwd_ready[j]) value = fwd_wdata[`DS_SLICE(j, XLEN)];
                    else              stall = rneed;
                end
            end
            // Producer in flight but not visible on any bypass.
            if (!hit && pending) stall = rneed;
        end
    end

endmodule

// File: rtl/ds_hazard_scoreboard.sv
// Decode-stage hazard unit: per-register pending-write counters plus
// NUM_RD prioritised bypass muxes; drives operand values and the ID stall.
module ds_hazard_scoreboard
    import ds_hazard_scoreboard_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int AW      = AW_DEF,
    parameter int NUM_RD  = NUM_RD_DEF,
    parameter int NUM_FWD = NUM_FWD_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    ds_valid,
    input  logic                    ds_fire,
    input  logic                    ds_rf_we,
    input  logic [AW-1:0]           ds_waddr,
    input  logic [NUM_RD*AW-1:0]    ds_raddr,
    input  logic [NUM_RD-1:0]       ds_rneed,
    input  logic [NUM_RD*XLEN-1:0]  rf_rdata,
    input  logic [NUM_FWD-1:0]      fwd_we,
    input  logic [NUM_FWD-1:0]      fwd_ready,
    input  logic [NUM_FWD*AW-1:0]   fwd_waddr,
    input  logic [NUM_FWD*XLEN-1:0] fwd_wdata,
    input  logic                    ws_retire,
    input  logic [AW-1:0]           ws_raddr,
    input  logic                    flush,
    output logic [NUM_RD*XLEN-1:0]  src_value,
    output logic                    ds_stall,
    output logic                    pending_any,
    output logic                    err_underflow
);

    localparam int              NREG    = 2 ** AW;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0]  cnt_q [NREG];
    logic [CNT_W-1:0]  cnt_d [NREG];
    logic              err_q, err_d;
    logic              inc, dec, waw;
    logic [NUM_RD-1:0] port_stall;
    logic [NUM_RD-1:0] port_pend;

    for (genvar i = 0; i < NUM_RD; i++) begin : g_port
        assign port_pend[i] = (cnt_q[ds_raddr[`DS_SLICE(i, AW)]] != '0);

        ds_fwd_mux #(
            .XLEN    (XLEN),
            .AW      (AW),
            .NUM_FWD (NUM_FWD)
        ) u_mux (
            .raddr     (ds_raddr[`DS_SLICE(i, AW)]),
            .rneed     (ds_rneed[i]),
            .rf_rdata  (rf_rdata[`DS_SLICE(i, XLEN)]),
            .pending   (port_pend[i]),
            .fwd_we    (fwd_we),
            .fwd_ready (fwd_ready),
            .fwd_waddr (fwd_waddr),
            .fwd_wdata (fwd_wdata),
            .value     (src_value[`DS_SLICE(i, XLEN)]),
            .stall     (port_stall[i])
        );
    end

    always_comb begin
        waw      = ds_rf_we && (ds_waddr != AW'(REG_ZERO)) && (cnt_q[ds_waddr] == CNT_MAX);
        ds_stall = ds_valid && ((|port_stall) || waw);
    end

    always_comb begin
        inc   = ds_fire && ds_rf_we && (ds_waddr != AW'(REG_ZERO));
        dec   = ws_retire && (ws_raddr != AW'(REG_ZERO));
        err_d = err_q;
        for (int r = 0; r < NREG; r++) cnt_d[r] = cnt_q[r];
        if (flush) begin
            for (int r = 0; r < NREG; r++) cnt_d[r] = '0;
        end else if (!(inc && dec && (ds_waddr == ws_raddr))) begin
            if (inc && (cnt_q[ds_waddr] != CNT_MAX))
                cnt_d[ds_waddr] = cnt_q[ds_waddr] + 1'b1;
            if (dec) begin
                if (cnt_q[ws_raddr] == '0) err_d = 1'b1;
                else                       cnt_d[ws_raddr] = cnt_q[ws_raddr] - 1'b1;
            end
        end
        cnt_d[REG_ZERO] = '0;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
            err_q <= 1'b0;
        end else begin
            for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
            err_q <= err_d;
        end
    end

    always_comb begin
        pending_any = 1'b0;
        for (int r = 0; r < NREG; r++) pending_any = pending_any | (cnt_q[r] != '0);
    end

    assign err_underflow = err_q;

endmodule
